j1_boot_loader: RTL and testbench

//  Boot sequencer for the j1 core: holds the core in reset, loads code RAM from
//  an 8-bit byte stream (UART/SPI front end), then releases the core.

---
 rtl/j1_boot_pkg.sv | 30 +++
 rtl/j1_boot_loader.sv | 167 ++++++++++++++++
 tb/tb_j1_boot_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_boot_pkg.sv
// ----------------------------------------------------------------------------
// j1_boot_pkg
// Shared types and constants for the j1 boot loader.
//   boot_state_t    : loader FSM states
//   BOOT_CSUM_INIT  : starting value of the data-byte checksum
//   RST_CNT_W       : width of the release (core reset stretch) counter
//   accepts_byte()  : 1 for the states that take a byte from the host stream
// ----------------------------------------------------------------------------
package j1_boot_pkg;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA_LO,
      DATA_HI,
      CSUM,
      RELEASE,
      RUN,
      ERROR
   } boot_state_t;

   localparam logic [7:0] BOOT_CSUM_INIT = 8'h00;
   localparam int         RST_CNT_W      = 8;

   function automatic logic accepts_byte(input boot_state_t s);
      return (s == HDR_LO) || (s == HDR_HI) || (s == DATA_LO) ||
             (s == DATA_HI) || (s == CSUM);
   endfunction

endpackage

// File: rtl/j1_boot_loader.sv
// ----------------------------------------------------------------------------
// j1_boot_loader
// Holds the j1 core in reset, loads code RAM from a byte stream
// (count N little-endian, then N words low byte first), then releases the
// core. A reboot_req in RUN or ERROR restarts the load.
//
// Optional feature: define J1_BOOT_CSUM_EN to expect one trailing byte equal
// to the mod-256 sum of all data bytes; a mismatch lands in ERROR.
//
// Ports
//   clk          in   single clock, posedge
//   reset        in   synchronous, active-high
//   rx_data      in   [7:0] boot byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   reboot_req   in   reload request, honoured in RUN and ERROR
//   code_we      out  code RAM write strobe (one cycle per word)
//   code_waddr   out  [CODE_AW-1:0] code RAM word address
//   code_wdata   out  [15:0] instruction word
//   core_resetq  out  0 = core held in reset; 1 only in RUN
//   booting      out  1 in every state except RUN and ERROR
//   boot_error   out  sticky error flag, cleared by reset or reboot_req
// ----------------------------------------------------------------------------
module j1_boot_loader
   import j1_boot_pkg::*;
#(
   parameter int CODE_AW    = 13,
   parameter int RST_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   input  logic               reboot_req,
   output logic               code_we,
   output logic [CODE_AW-1:0] code_waddr,
   output logic [15:0]        code_wdata,
   output logic               core_resetq,
   output logic               booting,
   output logic               boot_error
);

   // One extra bit so N = 2**CODE_AW is representable.
   localparam int                   IDX_W     = CODE_AW + 1;
   localparam logic [16:0]          MAX_WORDS = 17'(2 ** CODE_AW);
   localparam logic [RST_CNT_W-1:0] RST_LOAD  = RST_CNT_W'(RST_CYCLES);

`ifdef J1_BOOT_CSUM_EN
   localparam boot_state_t LOAD_DONE = CSUM;
   logic [7:0] csum;
`else
   localparam boot_state_t LOAD_DONE = RELEASE;
`endif

   boot_state_t          state, state_nxt;
   logic [7:0]           lo_byte;
   logic [IDX_W-1:0]     n_words;
   logic [IDX_W-1:0]     word_idx;
   logic [RST_CNT_W-1:0] rst_cnt;

   logic        xfer;
   logic [15:0] hdr_n;
   logic        last_word;
   logic        rebooting;

   assign xfer      = rx_valid & rx_ready;
   assign hdr_n     = {rx_data, lo_byte};
   assign last_word = (word_idx + IDX_W'(1)) == n_words;
   assign rebooting = reboot_req && ((state == RUN) || (state == ERROR));

   // NOTE: state_nxt is assigned a default before the case so no path leaves
   // it unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         HDR_LO:  if (xfer) state_nxt = HDR_HI;
         HDR_HI:
            if (xfer) begin
               if (hdr_n == 16'h0000)
                  state_nxt = LOAD_DONE;
               else if ({1'b0, hdr_n} > MAX_WORDS)
                  state_nxt = ERROR;
               else
                  state_nxt = DATA_LO;
            end
         DATA_LO: if (xfer) state_nxt = DATA_HI;
         DATA_HI: if (xfer) state_nxt = last_word ? LOAD_DONE : DATA_LO;
`ifdef J1_BOOT_CSUM_EN
         CSUM:    if (xfer) state_nxt = (rx_data == csum) ? RELEASE : ERROR;
`else
         CSUM:    state_nxt = ERROR;  // unreachable without the checksum
`endif
         // Counter runs RST_CYCLES..1 so RELEASE lasts RST_CYCLES cycles.
         RELEASE: if (rst_cnt <= RST_CNT_W'(1)) state_nxt = RUN;
         RUN:     if (reboot_req) state_nxt = HDR_LO;
         ERROR:   if (reboot_req) state_nxt = HDR_LO;
         default: state_nxt = HDR_LO;
      endcase
   end

   // Outputs are decoded from state_nxt and registered, so they change on the
   // same edge as the state and core_resetq never glitches.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= HDR_LO;
         rx_ready    <= 1'b1;
         code_we     <= 1'b0;
         code_waddr  <= '0;
         code_wdata  <= '0;
         core_resetq <= 1'b0;
         booting     <= 1'b1;
         boot_error  <= 1'b0;
         lo_byte     <= '0;
         n_words     <= '0;
         word_idx    <= '0;
         rst_cnt     <= '0;
`ifdef J1_BOOT_CSUM_EN
         csum        <= BOOT_CSUM_INIT;
`endif
      end else begin
         state       <= state_nxt;
         rx_ready    <= accepts_byte(state_nxt);
         core_resetq <= (state_nxt == RUN);
         booting     <= (state_nxt != RUN) && (state_nxt != ERROR);
         boot_error  <= (state_nxt == ERROR);
         code_we     <= 1'b0;

         if (xfer && ((state == HDR_LO) || (state == DATA_LO)))
            lo_byte <= rx_data;

         if (xfer && (state == HDR_HI)) begin
            // Safe truncation: oversize counts go to ERROR and are never used.
            n_words  <= hdr_n[IDX_W-1:0];
            word_idx <= '0;
         end

         if (xfer && (state == DATA_HI)) begin
            code_we    <= 1'b1;
            code_waddr <= word_idx[CODE_AW-1:0];
            code_wdata <= {rx_data, lo_byte};
            word_idx   <= word_idx + IDX_W'(1);
         end

`ifdef J1_BOOT_CSUM_EN
         if (xfer && ((state == DATA_LO) || (state == DATA_HI)))
            csum <= csum + rx_data;
`endif

         if ((state_nxt == RELEASE) && (state != RELEASE))
            rst_cnt <= RST_LOAD;
         else if (state == RELEASE)
            rst_cnt <= rst_cnt - RST_CNT_W'(1);

         if (rebooting) begin
            word_idx <= '0;
            rst_cnt  <= '0;
`ifdef J1_BOOT_CSUM_EN
            csum     <= BOOT_CSUM_INIT;
`endif
         end
      end
   end

endmodule

// File: tb/tb_j1_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_j1_boot_loader
// Directed bench for j1_boot_loader. Expected code RAM writes are queued as
// stimulus is issued; a negedge monitor pops and compares them whenever
// code_we is seen. Control outputs are checked inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_j1_boot_loader;

   localparam int CODE_AW    = 13;
   localparam int RST_CYCLES = 4;

   typedef struct packed {
      logic [CODE_AW-1:0] addr;
      logic [15:0]        data;
   } wr_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic               reboot_req;
   logic               code_we;
   logic [CODE_AW-1:0] code_waddr;
   logic [15:0]        code_wdata;
   logic               core_resetq;
   logic               booting;
   logic               boot_error;

   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q[$];
   wr_t  mon_e;
   logic [15:0] words[4];

   j1_boot_loader #(.CODE_AW(CODE_AW), .RST_CYCLES(RST_CYCLES)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .reboot_req  (reboot_req),
      .code_we     (code_we),
      .code_waddr  (code_waddr),
      .code_wdata  (code_wdata),
      .core_resetq (core_resetq),
      .booting     (booting),
      .boot_error  (boot_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (code_we === 1'b1) begin
         check("write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(code_waddr), 32'(mon_e.addr));
            check("write_data", 32'(code_wdata), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Drive one byte after an optional idle gap; returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic acc;
      logic ok;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         acc = rx_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      check("byte_accepted", 32'(ok), 32'd1);
      rx_valid = 1'b0;
   endtask

   // Full load of words[0..n-1]; queues the expected writes as bytes go out.
   task automatic load(input logic [15:0] n, input int max_gap);
      logic [7:0] sum;
      sum = 8'h00;
      send_byte(n[7:0],  $urandom_range(0, max_gap));
      send_byte(n[15:8], $urandom_range(0, max_gap));
      for (int i = 0; i < int'(n); i++) begin
         send_byte(words[i][7:0], $urandom_range(0, max_gap));
         exp_q.push_back('{addr: CODE_AW'(i), data: words[i]});
         send_byte(words[i][15:8], $urandom_range(0, max_gap));
         sum = sum + words[i][7:0] + words[i][15:8];
      end
`ifdef J1_BOOT_CSUM_EN
      send_byte(sum, $urandom_range(0, max_gap));
`endif
   endtask

   // Called #1 after the edge that entered RELEASE.
   task automatic expect_release();
      check("rel_resetq_low", 32'(core_resetq), 32'd0);
      for (int i = 1; i < RST_CYCLES; i++) begin
         @(posedge clk);
         #1;
         check("rel_resetq_hold", 32'(core_resetq), 32'd0);
         check("rel_booting", 32'(booting), 32'd1);
      end
      @(posedge clk);
      #1;
      check("run_resetq", 32'(core_resetq), 32'd1);
      check("run_booting", 32'(booting), 32'd0);
      check("run_rx_ready", 32'(rx_ready), 32'd0);
      check("run_boot_error", 32'(boot_error), 32'd0);
   endtask

   task automatic pulse_reboot();
      reboot_req = 1'b1;
      @(posedge clk);
      #1;
      reboot_req = 1'b0;
      check("reboot_resetq", 32'(core_resetq), 32'd0);
      check("reboot_rx_ready", 32'(rx_ready), 32'd1);
      check("reboot_booting", 32'(booting), 32'd1);
      check("reboot_boot_error", 32'(boot_error), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      reboot_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_code_we", 32'(code_we), 32'd0);
      check("rst_waddr", 32'(code_waddr), 32'd0);
      check("rst_wdata", 32'(code_wdata), 32'd0);
      check("rst_resetq", 32'(core_resetq), 32'd0);
      check("rst_booting", 32'(booting), 32'd1);
      check("rst_boot_error", 32'(boot_error), 32'd0);
      reset = 1'b0;

      // 1: two words, back-to-back bytes.
      words[0] = 16'h1234;
      words[1] = 16'h5678;
      load(16'd2, 0);
      expect_release();
      // RUN ignores the byte stream.
      rx_data  = 8'h5A;
      rx_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("run_ignores_bytes", 32'(rx_ready), 32'd0);
      end
      rx_valid = 1'b0;

      // 2: empty program.
      pulse_reboot();
      load(16'd0, 0);
      expect_release();

      // Boundary: N = 2**CODE_AW is accepted, then abandoned with reset.
      pulse_reboot();
      send_byte(8'h00, 0);
      send_byte(8'h20, 0);
      check("max_n_no_error", 32'(boot_error), 32'd0);
      check("max_n_rx_ready", 32'(rx_ready), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 3: N = 2**CODE_AW + 1 is rejected.
      send_byte(8'h01, 0);
      send_byte(8'h20, 0);
      check("err_boot_error", 32'(boot_error), 32'd1);
      check("err_resetq", 32'(core_resetq), 32'd0);
      check("err_rx_ready", 32'(rx_ready), 32'd0);
      check("err_booting", 32'(booting), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("err_sticky", 32'(boot_error), 32'd1);
      pulse_reboot();

      // 4: same payload as 1 with random gaps on rx_valid.
      load(16'd2, 3);
      expect_release();

      // 5: reboot from RUN, one-word reload, then reset mid-DATA_HI.
      pulse_reboot();
      words[0] = 16'hABCD;
      load(16'd1, 0);
      expect_release();
      pulse_reboot();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      rx_data  = 8'hBE;
      rx_valid = 1'b1;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      rx_valid = 1'b0;
      check("midrst_rx_ready", 32'(rx_ready), 32'd1);
      check("midrst_booting", 32'(booting), 32'd1);
      check("midrst_code_we", 32'(code_we), 32'd0);
      check("midrst_resetq", 32'(core_resetq), 32'd0);
      repeat (2) @(posedge clk);
      #1;

`ifdef J1_BOOT_CSUM_EN
      // 6: checksum good (0x10+0x20 = 0x30) then bad (0x31).
      words[0] = 16'h2010;
      load(16'd1, 0);
      expect_release();
      pulse_reboot();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      exp_q.push_back('{addr: CODE_AW'(0), data: 16'h2010});
      send_byte(8'h20, 0);
      send_byte(8'h31, 0);
      check("csum_bad_error", 32'(boot_error), 32'd1);
      check("csum_bad_resetq", 32'(core_resetq), 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("writes_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
